// File: rtl/mod_mon_pkg.sv
// Shared definitions for the modulated-clock signal monitor.
package mod_mon_pkg;

   localparam int CNT_W_DEF       = 16;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [0:0] {
      S_WAIT = 1'b0,
      S_MEAS = 1'b1
   } mon_state_e;

endpackage

// File: rtl/mod_mon_sync_edge.sv
// Multi-flop synchronizer followed by a registered rise/fall detector.
module mod_mon_sync_edge
   import mod_mon_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF   // minimum 2
) (
   input  logic user_clock,
   input  logic rst_b,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [SYNC_STAGES:0]   vld_q;

   assign level = sync_q[SYNC_STAGES-1];

   // vld_q keeps the all-zero reset contents of the pipeline from reading as an edge
   always_ff @(posedge user_clock or negedge rst_b) begin
      if (!rst_b) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         vld_q  <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
         vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
         rise   <= vld_q[SYNC_STAGES] &  sync_q[SYNC_STAGES-1] & ~prev_q;
         fall   <= vld_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1] &  prev_q;
      end
   end

endmodule

// File: rtl/mod_signal_monitor.sv
// Measures period, high time and CLKL phase of a modulated clock.
// Optional overlap check on CLK/CLKN: define MOD_MON_OVERLAP_CHECK_EN.
//
// state  | meaning
// S_WAIT | idle or after timeout, waiting for a CLK rise to open a period
// S_MEAS | counting cycles inside a period, publishing on each closing rise
module mod_signal_monitor
   import mod_mon_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             user_clock,
   input  logic             rst_b,
   input  logic             clk_mod,
   input  logic             clkn_mod,
   input  logic             clkl_mod,
   input  logic             clr_err,
   output logic             meas_valid,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic [CNT_W-1:0] phase_out,
   output logic             phase_ok,
   output logic             no_signal,
   output logic             overlap_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic clk_lvl, clk_rise, clk_fall;
   logic clkl_rise;
   logic unused_clkl_lvl, unused_clkl_fall;

   mod_mon_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .user_clock (user_clock),
      .rst_b      (rst_b),
      .async_in   (clk_mod),
      .level      (clk_lvl),
      .rise       (clk_rise),
      .fall       (clk_fall)
   );

   mod_mon_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clkl (
      .user_clock (user_clock),
      .rst_b      (rst_b),
      .async_in   (clkl_mod),
      .level      (unused_clkl_lvl),
      .rise       (clkl_rise),
      .fall       (unused_clkl_fall)
   );

`ifdef MOD_MON_OVERLAP_CHECK_EN
   logic clkn_lvl, both_q;
   logic unused_clkn_rise, unused_clkn_fall;

   mod_mon_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clkn (
      .user_clock (user_clock),
      .rst_b      (rst_b),
      .async_in   (clkn_mod),
      .level      (clkn_lvl),
      .rise       (unused_clkn_rise),
      .fall       (unused_clkn_fall)
   );

   // a single-cycle overlap is tolerated as synchronizer skew
   always_ff @(posedge user_clock or negedge rst_b) begin
      if (!rst_b) begin
         both_q      <= 1'b0;
         overlap_err <= 1'b0;
      end else begin
         both_q <= clk_lvl & clkn_lvl;
         if (clk_lvl & clkn_lvl & both_q)
            overlap_err <= 1'b1;
         else if (clr_err)
            overlap_err <= 1'b0;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg  = clkn_mod ^ clk_lvl;
   assign overlap_err = 1'b0;
`endif

   mon_state_e       state_q;
   logic [CNT_W-1:0] cnt_q, high_q, phase_q;
   logic             seen_q;
   logic             timeout;

   assign timeout = (state_q == S_MEAS) && (cnt_q == CNT_MAX);

   always_ff @(posedge user_clock or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= S_WAIT;
         cnt_q      <= '0;
         high_q     <= '0;
         phase_q    <= '0;
         seen_q     <= 1'b0;
         meas_valid <= 1'b0;
         period_out <= '0;
         high_out   <= '0;
         phase_out  <= '0;
         phase_ok   <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         case (state_q)
            S_WAIT: begin
               if (clk_rise) begin
                  cnt_q   <= '0;
                  phase_q <= '0;
                  seen_q  <= clkl_rise;
                  state_q <= S_MEAS;
               end
            end
            S_MEAS: begin
               if (timeout) begin
                  state_q <= S_WAIT;
               end else if (clk_rise) begin
                  meas_valid <= 1'b1;
                  period_out <= cnt_q + 1'b1;
                  high_out   <= high_q;
                  phase_out  <= phase_q;
                  phase_ok   <= seen_q;
                  cnt_q      <= '0;
                  phase_q    <= '0;
                  seen_q     <= clkl_rise;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (clk_fall)
                     high_q <= cnt_q + 1'b1;
                  if (clkl_rise && !seen_q) begin
                     phase_q <= cnt_q + 1'b1;
                     seen_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= S_WAIT;
         endcase
      end
   end

   always_ff @(posedge user_clock or negedge rst_b) begin
      if (!rst_b)
         no_signal <= 1'b0;
      else if (timeout)
         no_signal <= 1'b1;
      else if (clr_err)
         no_signal <= 1'b0;
   end

endmodule

// File: tb/tb_mod_signal_monitor.sv
// Scoreboard bench for mod_signal_monitor; follows MOD_MON_OVERLAP_CHECK_EN for overlap expectations.
`timescale 1ns/10ps
module tb_mod_signal_monitor;

   localparam int CNT_W       = 16;
   localparam int SYNC_STAGES = 2;

   logic             user_clock = 1'b0;
   logic             rst_b      = 1'b0;
   logic             clk_mod, clkn_mod, clkl_mod;
   logic             clr_err    = 1'b0;
   logic             meas_valid;
   logic [CNT_W-1:0] period_out, high_out, phase_out;
   logic             phase_ok, no_signal, overlap_err;

   mod_signal_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .user_clock  (user_clock),
      .rst_b       (rst_b),
      .clk_mod     (clk_mod),
      .clkn_mod    (clkn_mod),
      .clkl_mod    (clkl_mod),
      .clr_err     (clr_err),
      .meas_valid  (meas_valid),
      .period_out  (period_out),
      .high_out    (high_out),
      .phase_out   (phase_out),
      .phase_ok    (phase_ok),
      .no_signal   (no_signal),
      .overlap_err (overlap_err)
   );

   always #5 user_clock = ~user_clock;

   typedef struct {
      int period;
      int high_lo;
      int high_hi;
      int phase_lo;
      int phase_hi;
      bit chk_phase;
      bit phase_ok;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input longint obs, input longint exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // pin generator, 0.5 ns steps offset from the sampling edges
   // mode 0: idle (CLK low, CLKN high), 1: run, 2: CLK and CLKN both forced high
   int mode    = 0;
   int per     = 2000;
   int hi      = 1000;
   int lag     = 0;
   bit clkl_en = 1'b1;
   int gen_ph;
   int gen_prev;

   initial begin
      gen_ph   = 0;
      gen_prev = 0;
      clk_mod  = 1'b0;
      clkn_mod = 1'b1;
      clkl_mod = 1'b0;
      #0.25;
      forever begin
         if (mode == 1) begin
            if (gen_prev != 1) gen_ph = 0;
            clk_mod  = (gen_ph < hi);
            clkn_mod = !(gen_ph < hi);
            clkl_mod = clkl_en && (((gen_ph - lag + per) % per) < per / 2);
            gen_ph   = (gen_ph + 1) % per;
         end else if (mode == 2) begin
            clk_mod  = 1'b1;
            clkn_mod = 1'b1;
            clkl_mod = 1'b0;
         end else begin
            clk_mod  = 1'b0;
            clkn_mod = 1'b1;
            clkl_mod = 1'b0;
         end
         gen_prev = mode;
         #0.5;
      end
   end

   always @(negedge user_clock) begin
      if (rst_b && meas_valid) begin
         if (sb_q.size() == 0) begin
            chk("extra_pub", meas_valid, 0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("period", period_out, mon_e.period);
            chk("high", high_out, clamp(int'(high_out), mon_e.high_lo, mon_e.high_hi));
            if (mon_e.chk_phase)
               chk("phase", phase_out, clamp(int'(phase_out), mon_e.phase_lo, mon_e.phase_hi));
            chk("phase_ok", phase_ok, mon_e.phase_ok);
         end
      end
   end

   task automatic push(input int n, input exp_t e);
      for (int i = 0; i < n; i++) sb_q.push_back(e);
   endtask

   task automatic drain(input string tag, input int budget);
      int c = 0;
      while (sb_q.size() != 0 && c < budget) begin
         @(negedge user_clock);
         c++;
      end
      chk({tag, "_drain"}, sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic do_reset();
      mode = 0;
      #2;
      rst_b = 1'b0;
      repeat (3) @(posedge user_clock);
      #1 rst_b = 1'b1;
      repeat (6) @(posedge user_clock);
   endtask

   task automatic pulse_clr();
      @(posedge user_clock);
      #1 clr_err = 1'b1;
      @(posedge user_clock);
      #1 clr_err = 1'b0;
   endtask

   exp_t e_1m, e_4m, e_2m;
   int   c;
   bit   exp_ovl;

   initial begin
      e_1m = '{100, 50, 50, 0, 0, 1'b1, 1'b1};
      e_4m = '{25, 6, 7, 6, 7, 1'b1, 1'b1};
      e_2m = '{50, 15, 15, 0, 0, 1'b0, 1'b0};
`ifdef MOD_MON_OVERLAP_CHECK_EN
      exp_ovl = 1'b1;
`else
      exp_ovl = 1'b0;
`endif

      repeat (3) @(posedge user_clock);
      @(negedge user_clock);
      chk("rst_valid", meas_valid, 0);
      chk("rst_period", period_out, 0);
      chk("rst_high", high_out, 0);
      chk("rst_phase", phase_out, 0);
      chk("rst_phase_ok", phase_ok, 0);
      chk("rst_no_signal", no_signal, 0);
      chk("rst_overlap", overlap_err, 0);
      #1 rst_b = 1'b1;
      repeat (6) @(posedge user_clock);

      // 1 MHz, 50 % duty, CLKL in phase
      per = 2000; hi = 1000; lag = 0; clkl_en = 1'b1;
      push(4, e_1m);
      mode = 1;
      drain("s1", 700);
      mode = 0;
      chk("ovl_normal", overlap_err, 0);
      chk("nosig_normal", no_signal, 0);
      do_reset();

      // 4 MHz, 25 % duty, CLKL lagging 90 degrees
      per = 500; hi = 125; lag = 125;
      push(6, e_4m);
      mode = 1;
      drain("s2", 300);
      mode = 0;
      do_reset();

      // 2 MHz, 30 % duty, CLKL held low
      per = 1000; hi = 300; lag = 0; clkl_en = 1'b0;
      push(4, e_2m);
      mode = 1;
      drain("s3", 400);
      mode = 0;
      clkl_en = 1'b1;
      do_reset();

      // three periods, then CLK stops until the edge timeout fires
      per = 2000; hi = 1000; lag = 0;
      push(3, e_1m);
      mode = 1;
      drain("s4", 700);
      mode = 0;
      repeat (60000) @(negedge user_clock);
      chk("nosig_early", no_signal, 0);
      c = 0;
      while (!no_signal && c < 10000) begin
         @(negedge user_clock);
         c++;
      end
      chk("nosig_set", no_signal, 1);
      repeat (200) @(negedge user_clock);
      chk("nosig_sticky", no_signal, 1);
      pulse_clr();
      @(negedge user_clock);
      chk("nosig_clr", no_signal, 0);
      push(2, e_1m);
      mode = 1;
      drain("s4_resume", 500);
      mode = 0;
      chk("nosig_resume", no_signal, 0);
      do_reset();

      // CLK and CLKN forced high together
      mode = 2;
      repeat (5) @(posedge user_clock);
      #1 mode = 0;
      repeat (6) @(negedge user_clock);
      chk("ovl_set", overlap_err, exp_ovl);
      repeat (4) @(negedge user_clock);
      chk("ovl_sticky", overlap_err, exp_ovl);
      pulse_clr();
      @(negedge user_clock);
      chk("ovl_clr", overlap_err, 0);
      do_reset();

      // reset pulsed mid-period while CLK is high
      per = 2000; hi = 1000; lag = 0;
      push(1, e_1m);
      mode = 1;
      drain("s6_pre", 400);
      repeat (20) @(posedge user_clock);
      #2 rst_b = 1'b0;
      #1;
      chk("mid_rst_valid", meas_valid, 0);
      chk("mid_rst_period", period_out, 0);
      chk("mid_rst_high", high_out, 0);
      chk("mid_rst_phase_ok", phase_ok, 0);
      repeat (3) @(posedge user_clock);
      #1 rst_b = 1'b1;
      push(1, e_1m);
      drain("s6_post", 400);
      mode = 0;
      repeat (10) @(negedge user_clock);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mod_signal_monitor.md
MOD_SIGNAL_MONITOR -- requirements
Module: mod_signal_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of all cycle counters and measurement outputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop stages per asynchronous input synchronizer, minimum 2.
REQ-003 USER_CLOCK  input  1  sampling clock; sole clock of the block.
REQ-004 RST_B  input  1  reset, asynchronous assert, active-low.
REQ-005 CLK_MOD  input  1  modulated clock from the imager-side loopback; asynchronous to USER_CLOCK.
REQ-006 CLKN_MOD  input  1  complementary modulated clock; asynchronous.
REQ-007 CLKL_MOD  input  1  light-source modulation; asynchronous.
REQ-008 CLR_ERR  input  1  synchronous clear of OVERLAP_ERR and NO_SIGNAL.
REQ-009 MEAS_VALID  output  1  one-cycle pulse when a new measurement is published.
REQ-010 PERIOD_OUT  output  CNT_W  USER_CLOCK cycles per CLK_MOD period.
REQ-011 HIGH_OUT  output  CNT_W  USER_CLOCK cycles for which CLK_MOD is high.
REQ-012 PHASE_OUT  output  CNT_W  cycles from CLK_MOD rise to CLKL_MOD rise.
REQ-013 PHASE_OK  output  1  a CLKL_MOD rise occurred within the published period.
REQ-014 NO_SIGNAL  output  1  sticky flag: CLK_MOD edge timeout.
REQ-015 OVERLAP_ERR  output  1  sticky flag: CLK_MOD and CLKN_MOD both high.

Function
REQ-016 Each CLK*_MOD input SHALL pass through a SYNC_STAGES synchronizer, then a one-flop edge detector; "rise" and "fall" refer to the synchronized signals.
REQ-017 FSM states: S_WAIT (waiting for the first CLK rise) and S_MEAS (counting).
REQ-018 S_WAIT: on CLK rise, clear cnt to 0, clear phase-seen, and go to S_MEAS; no publication occurs.
REQ-019 S_MEAS: cnt SHALL increment by 1 each cycle.
REQ-020 S_MEAS: on CLK fall, capture high = cnt+1.
REQ-021 S_MEAS: on the first CLKL rise, capture phase = cnt+1 and set phase-seen.
REQ-022 If CLKL rise coincides with the CLK rise that opens a period, phase SHALL be 0 and phase-seen 1.
REQ-023 S_MEAS: on the next CLK rise, register PERIOD_OUT = cnt+1, HIGH_OUT = high, PHASE_OUT = phase and PHASE_OK = phase-seen; the same cycle SHALL restart cnt and phase-seen for the next period.
REQ-024 MEAS_VALID SHALL assert in the cycle after the closing rise is detected, for exactly one cycle; outputs SHALL hold until the next publication.
REQ-025 A CLKL rise on the same cycle as a closing CLK rise SHALL count toward the new period with phase 0.
REQ-026 If cnt reaches 2^CNT_W-1 in S_MEAS, the block SHALL set NO_SIGNAL, go to S_WAIT, and not publish.
REQ-027 NO_SIGNAL SHALL stay set until CLR_ERR or reset; measurements resume after the next CLK rise.
REQ-028 If CLR_ERR and a setting event occur in the same cycle, set SHALL win.
REQ-029 End-to-end latency from a CLK_MOD pin edge to MEAS_VALID is SYNC_STAGES+2 cycles.

Reset
REQ-030 While RST_B is low: FSM = S_WAIT; all counters, synchronizers, and outputs = 0.
REQ-031 Deasserting RST_B mid-period SHALL discard the partial period; the first MEAS_VALID requires two full CLK rises.

Configuration
REQ-032 With MOD_MON_OVERLAP_CHECK_EN defined: OVERLAP_ERR SHALL set on any cycle where synchronized CLK and CLKN are both 1 for 2 or more consecutive cycles.
REQ-033 Without MOD_MON_OVERLAP_CHECK_EN: OVERLAP_ERR is tied to 0 and the CLKN synchronizer is not built.

Structure
REQ-034 Shared package mod_mon_pkg SHALL hold the FSM state enum, the CNT_W default, and the SYNC_STAGES default.
REQ-035 Single sub-module mod_mon_sync_edge: synchronizer plus rise/fall detector, instantiated per input.

Verification
REQ-036 USER_CLOCK 100 MHz, CLK_MOD 1 MHz at 50% duty, CLKL in phase -> PERIOD_OUT=100, HIGH_OUT=50, PHASE_OUT=0, PHASE_OK=1, one MEAS_VALID per microsecond.
REQ-037 CLK_MOD 4 MHz at 25% duty, CLKL lagging 90 degrees -> PERIOD_OUT=25, HIGH_OUT=6 or 7, PHASE_OUT=6 or 7.
REQ-038 CLKL held low -> PHASE_OK=0 on every publication.
REQ-039 CLK_MOD stopped after 3 periods -> after 65535 cycles NO_SIGNAL=1 with no further MEAS_VALID; restart plus CLR_ERR -> NO_SIGNAL=0 and measurements resume.
REQ-040 With the macro defined, CLK and CLKN forced high together for 5 cycles -> OVERLAP_ERR=1; with the macro undefined, OVERLAP_ERR stays 0.
REQ-041 RST_B pulsed low mid-period -> all outputs 0 immediately; the first MEAS_VALID appears after the second subsequent CLK rise.
